// File: rtl/pipe_skip_adder_pkg.sv
// Shared definitions for the pipelined carry-skip adder: stage-count helper,
// geometry check and the control part of a pipeline stage record.
package adder_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
        logic pacc;
    } stage_ctl_t;

    function automatic int nblk(input int width, input int block);
        return width / block;
    endfunction

    function automatic bit geom_ok(input int width, input int block);
        return (block >= 32'sd1) && ((width % block) == 32'sd0);
    endfunction

endpackage

// File: rtl/pipe_skip_adder_skip_block.sv
// Combinational BLOCK-bit carry-skip slice: ripple sum plus a skip mux that
// forwards the carry-in straight to the carry-out when every bit propagates.
module skip_block #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             bp,
    output logic             c_msb
);

    logic [BLOCK-1:0] p_s;
    logic [BLOCK-1:0] g_s;
    logic [BLOCK:0]   c_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // ripple carry chain through the slice
    always_comb begin
        c_s    = '0;
        c_s[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
        end
    end

    assign sum   = p_s ^ c_s[BLOCK-1:0];
    assign bp    = &p_s;
    assign c_msb = c_s[BLOCK-1];
    assign cout  = bp ? cin : c_s[BLOCK];

endmodule

// File: rtl/pipe_skip_adder.sv
// Pipelined carry-skip adder: one BLOCK-bit slice per stage, valid/ready
// handshake, full-pipeline hold on stall. Optional PIPE_SKIP_ADDER_SUB_EN adds a sub port.
module pipe_skip_adder
    import adder_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int BLOCK = 8,
    localparam int NBLK  = nblk(WIDTH, BLOCK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_SKIP_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             pout,
    output logic             ovf
);

    if (!geom_ok(WIDTH, BLOCK)) begin : g_bad_geom
        $error("pipe_skip_adder: WIDTH must be a positive multiple of BLOCK");
    end

    logic             stall_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;

    assign stall_s  = out_valid & ~out_ready;
    assign in_ready = ~stall_s;

    // operand conditioning at the pipeline entry
    always_comb begin
        b_eff_s   = b;
        cin_eff_s = cin;
`ifdef PIPE_SKIP_ADDER_SUB_EN
        if (sub) begin
            b_eff_s   = ~b;
            cin_eff_s = 1'b1;
        end else begin
            b_eff_s   = b;
            cin_eff_s = cin;
        end
`endif
    end

    for (genvar k = 0; k < NBLK; k++) begin : stg
        localparam int LO = (k + 1) * BLOCK;
        localparam int HI = WIDTH - LO;

        logic [BLOCK-1:0] a_blk_s;
        logic [BLOCK-1:0] b_blk_s;
        logic [BLOCK-1:0] blk_sum_s;
        logic             c_in_s;
        logic             p_in_s;
        logic             v_in_s;
        logic             blk_cout_s;
        logic             blk_bp_s;
        logic             blk_cmsb_s;
        logic [LO-1:0]    sum_nxt_s;
        stage_ctl_t       ctl_r;
        logic [LO-1:0]    sum_lo_r;

        if (k == 0) begin : g_head
            assign a_blk_s   = a[BLOCK-1:0];
            assign b_blk_s   = b_eff_s[BLOCK-1:0];
            assign c_in_s    = cin_eff_s;
            assign p_in_s    = 1'b1;
            assign v_in_s    = in_valid & in_ready;
            assign sum_nxt_s = blk_sum_s;
        end else begin : g_body
            assign a_blk_s   = stg[k-1].g_hi.a_hi_r[BLOCK-1:0];
            assign b_blk_s   = stg[k-1].g_hi.b_hi_r[BLOCK-1:0];
            assign c_in_s    = stg[k-1].ctl_r.carry;
            assign p_in_s    = stg[k-1].ctl_r.pacc;
            assign v_in_s    = stg[k-1].ctl_r.valid;
            assign sum_nxt_s = {blk_sum_s, stg[k-1].sum_lo_r};
        end

        skip_block #(
            .BLOCK(BLOCK)
        ) u_blk (
            .a    (a_blk_s),
            .b    (b_blk_s),
            .cin  (c_in_s),
            .sum  (blk_sum_s),
            .cout (blk_cout_s),
            .bp   (blk_bp_s),
            .c_msb(blk_cmsb_s)
        );

        // stage control and accumulated low sum; bubbles hold too on stall
        always_ff @(posedge clk) begin
            if (rst) begin
                ctl_r    <= '0;
                sum_lo_r <= '0;
            end else if (!stall_s) begin
                ctl_r.valid <= v_in_s;
                ctl_r.carry <= blk_cout_s;
                ctl_r.pacc  <= p_in_s & blk_bp_s;
                sum_lo_r    <= sum_nxt_s;
            end
        end

        if (HI > 0) begin : g_hi
            logic [HI-1:0] a_hi_r;
            logic [HI-1:0] b_hi_r;
            logic [HI-1:0] a_hi_nxt_s;
            logic [HI-1:0] b_hi_nxt_s;
            // only the last slice needs the carry into the word MSB
            logic          cmsb_unused_s;

            assign cmsb_unused_s = blk_cmsb_s;

            if (k == 0) begin : g_src_in
                assign a_hi_nxt_s = a[WIDTH-1:BLOCK];
                assign b_hi_nxt_s = b_eff_s[WIDTH-1:BLOCK];
            end else begin : g_src_prev
                assign a_hi_nxt_s = stg[k-1].g_hi.a_hi_r[HI+BLOCK-1:BLOCK];
                assign b_hi_nxt_s = stg[k-1].g_hi.b_hi_r[HI+BLOCK-1:BLOCK];
            end

            // skew registers carrying the not-yet-added operand bits
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_hi_r <= '0;
                    b_hi_r <= '0;
                end else if (!stall_s) begin
                    a_hi_r <= a_hi_nxt_s;
                    b_hi_r <= b_hi_nxt_s;
                end
            end
        end else begin : g_tail
            logic ovf_r;

            // carry into MSB folded with carry out of MSB
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (!stall_s) begin
                    ovf_r <= blk_cmsb_s ^ blk_cout_s;
                end
            end

            assign out_valid = ctl_r.valid;
            assign sum       = sum_lo_r;
            assign cout      = ctl_r.carry;
            assign pout      = ctl_r.pacc;
            assign ovf       = ovf_r;
        end
    end

endmodule
